rf_write_arbiter: RTL and testbench

- Shares the single register-file write port between the pipeline writeback stage and an auxiliary result source, such as a multi-cycle mult/div unit or a late load return.
- Pipeline writeback always has priority.
- Auxiliary results are queued in a small buffer and drained into idle write-port cycles.
- A starvation guard requests a pipeline stall, and a WAW guard kills stale queued writes.

---
 rtl/rf_write_arbiter.sv | 133 +++++++++++++
 tb/tb_rf_write_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the single register-file write port between the
// pipeline writeback stage (always wins) and a small in-order buffer of
// auxiliary results that drain into idle port cycles. Queued entries are
// killed when a pipeline write to the same register overtakes them, and a
// starvation counter raises an advisory stall request.
module rf_write_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_reg_write,
    input  logic [4:0]                 wb_write_register,
    input  logic [31:0]                wb_write_data,
    input  logic                       aux_valid,
    output logic                       aux_ready,
    input  logic [4:0]                 aux_register,
    input  logic [31:0]                aux_data,
    output logic                       rf_we,
    output logic [4:0]                 rf_waddr,
    output logic [31:0]                rf_wdata,
    output logic                       stall_pipe,
    output logic [$clog2(DEPTH+1)-1:0] buf_count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [STV_W-1:0] STV_LIMIT = STV_W'(STARVE_LIMIT);

    logic             live_q [DEPTH];
    logic [4:0]       reg_q  [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [STV_W-1:0] starve_q, starve_d;
    logic             stall_q, stall_d;

    logic nonempty, head_live, pw, accept, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Handshake, pop decision and occupancy bookkeeping
    always_comb begin
        nonempty  = (count_q != '0);
        head_live = nonempty && live_q[head_q];
        pw        = wb_reg_write && (wb_write_register != 5'd0);
        aux_ready = (count_q != CNT_FULL);
        accept    = aux_valid && aux_ready;
        push      = accept && (aux_register != 5'd0);
        // a dead head always leaves; a live head leaves only when it owns the port
        pop       = nonempty && (!live_q[head_q] || !pw);
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Write-port mux: pipeline first, then a live buffer head
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (!rst) begin
            if (pw) begin
                rf_we    = 1'b1;
                rf_waddr = wb_write_register;
                rf_wdata = wb_write_data;
            end else if (head_live) begin
                rf_we    = 1'b1;
                rf_waddr = reg_q[head_q];
                rf_wdata = data_q[head_q];
            end
        end
    end

    // Starvation counter next state; stall follows the saturated count
    always_comb begin
        starve_d = starve_q;
        if (!nonempty || pop) begin
            starve_d = '0;
        end else if (head_live && pw && (starve_q != STV_LIMIT)) begin
            starve_d = starve_q + 1'b1;
        end
        stall_d = (starve_d == STV_LIMIT);
    end

    // Buffer storage: WAW kill of existing entries, then push and pop
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) live_q[i] <= 1'b0;
        end else begin
            if (pw) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (reg_q[i] == wb_write_register) live_q[i] <= 1'b0;
                end
            end
            // the same-cycle push is younger than the pipeline write, so it overrides the kill
            if (push) begin
                live_q[tail_q] <= 1'b1;
                reg_q[tail_q]  <= aux_register;
                data_q[tail_q] <= aux_data;
                tail_q         <= ptr_inc(tail_q);
            end
            if (pop) head_q <= ptr_inc(head_q);
            count_q <= count_d;
        end
    end

    // Starvation counter and registered stall request
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    assign stall_pipe = stall_q;
    assign buf_count  = count_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: a queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations, then random traffic.
module tb_rf_write_arbiter;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_reg_write;
    logic [4:0]  wb_write_register;
    logic [31:0] wb_write_data;
    logic        aux_valid;
    logic        aux_ready;
    logic [4:0]  aux_register;
    logic [31:0] aux_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall_pipe;
    logic [$clog2(DEPTH+1)-1:0] buf_count;

    rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .wb_reg_write(wb_reg_write), .wb_write_register(wb_write_register),
        .wb_write_data(wb_write_data),
        .aux_valid(aux_valid), .aux_ready(aux_ready),
        .aux_register(aux_register), .aux_data(aux_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .stall_pipe(stall_pipe), .buf_count(buf_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          live;
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    int   starve = 0;
    bit   stall  = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs (called just after a falling edge) and
    // compare every output against the model.
    task automatic drive(input bit r, input bit wbw, input logic [4:0] wbr, input logic [31:0] wbd,
                         input bit av, input logic [4:0] ar, input logic [31:0] ad);
        bit          e_we;
        logic [4:0]  e_a;
        logic [31:0] e_d;
        bit          pwv;
        rst = r; wb_reg_write = wbw; wb_write_register = wbr; wb_write_data = wbd;
        aux_valid = av; aux_register = ar; aux_data = ad;
        #1;
        pwv = wbw && (wbr != 0);
        e_we = 0; e_a = 0; e_d = 0;
        if (!r) begin
            if (pwv) begin
                e_we = 1; e_a = wbr; e_d = wbd;
            end else if (q.size() != 0 && q[0].live) begin
                e_we = 1; e_a = q[0].r; e_d = q[0].d;
            end
        end
        chk("model_rf_we", 64'(rf_we), 64'(e_we));
        if (!r) begin
            chk("model_rf_waddr", 64'(rf_waddr), 64'(e_a));
            chk("model_rf_wdata", 64'(rf_wdata), 64'(e_d));
            chk("model_aux_ready", 64'(aux_ready), 64'(q.size() < DEPTH));
        end
        chk("model_buf_count", 64'(buf_count), 64'(q.size()));
        chk("model_stall_pipe", 64'(stall_pipe), 64'(stall));
    endtask

    // Advance the model by the clock edge using the currently applied inputs.
    task automatic tick();
        bit   ne, hl, pwv, acc, popped;
        ent_t e;
        if (rst) begin
            q.delete();
            starve = 0;
            stall  = 0;
        end else begin
            ne     = (q.size() != 0);
            hl     = ne && q[0].live;
            pwv    = wb_reg_write && (wb_write_register != 0);
            acc    = aux_valid && (q.size() < DEPTH);
            popped = ne && (!hl || !pwv);
            if (pwv) foreach (q[i]) if (q[i].r == wb_write_register) q[i].live = 0;
            if (popped) void'(q.pop_front());
            if (acc && aux_register != 0) begin
                e.live = 1; e.r = aux_register; e.d = aux_data;
                q.push_back(e);
            end
            if (!ne || popped) starve = 0;
            else if (hl && pwv && starve < STARVE_LIMIT) starve++;
            stall = (starve == STARVE_LIMIT);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cyc(input bit r, input bit wbw, input logic [4:0] wbr, input logic [31:0] wbd,
                       input bit av, input logic [4:0] ar, input logic [31:0] ad);
        drive(r, wbw, wbr, wbd, av, ar, ad);
        tick();
    endtask

    initial begin
        int pct;
        rst = 1; wb_reg_write = 0; wb_write_register = 0; wb_write_data = 0;
        aux_valid = 0; aux_register = 0; aux_data = 0;
        @(negedge clk);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);

        // reset state
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("rst_buf_count", 64'(buf_count), 64'd0);
        chk("rst_aux_ready", 64'(aux_ready), 64'd1);
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_stall", 64'(stall_pipe), 64'd0);
        tick();

        // idle pipeline: aux r5 written the next cycle
        drive(0, 0, 0, 0, 1, 5, 32'hDEADBEEF);
        chk("idle_accept_we", 64'(rf_we), 64'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("idle_we", 64'(rf_we), 64'd1);
        chk("idle_waddr", 64'(rf_waddr), 64'd5);
        chk("idle_wdata", 64'(rf_wdata), 64'hDEADBEEF);
        chk("idle_count1", 64'(buf_count), 64'd1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("idle_count0", 64'(buf_count), 64'd0);
        tick();

        // conflict: r7 waits behind three pipeline writes to r3
        drive(0, 1, 3, 32'h33, 1, 7, 32'h77);
        chk("conf_waddr0", 64'(rf_waddr), 64'd3);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 3, 32'h33, 0, 0, 0);
            chk("conf_waddr", 64'(rf_waddr), 64'd3);
            chk("conf_stall", 64'(stall_pipe), 64'd0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("conf_aux_we", 64'(rf_we), 64'd1);
        chk("conf_aux_waddr", 64'(rf_waddr), 64'd7);
        chk("conf_aux_wdata", 64'(rf_wdata), 64'h77);
        chk("conf_stall_end", 64'(stall_pipe), 64'd0);
        tick();

        // starvation: r9 blocked by r1 writes for four cycles
        cyc(0, 1, 1, 32'h1, 1, 9, 32'h99);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1, 32'h1, 0, 0, 0);
            chk("starve_no_stall_yet", 64'(stall_pipe), 64'd0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("starve_stall", 64'(stall_pipe), 64'd1);
        chk("starve_waddr", 64'(rf_waddr), 64'd9);
        chk("starve_wdata", 64'(rf_wdata), 64'h99);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("starve_release", 64'(stall_pipe), 64'd0);
        chk("starve_count", 64'(buf_count), 64'd0);
        tick();

        // WAW kill: queued r4=0x11 overtaken by pipeline r4=0x22
        cyc(0, 0, 0, 0, 1, 4, 32'h11);
        drive(0, 1, 4, 32'h22, 0, 0, 0);
        chk("waw_wdata", 64'(rf_wdata), 64'h22);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("waw_dead_we", 64'(rf_we), 64'd0);
        chk("waw_dead_count", 64'(buf_count), 64'd1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("waw_count0", 64'(buf_count), 64'd0);
        tick();

        // full buffer
        cyc(0, 1, 1, 32'h1, 1, 2, 32'hA2);
        cyc(0, 1, 1, 32'h1, 1, 3, 32'hA3);
        drive(0, 1, 1, 32'h1, 1, 6, 32'hA6);
        chk("full_ready", 64'(aux_ready), 64'd0);
        chk("full_count", 64'(buf_count), 64'd2);
        tick();
        drive(0, 1, 0, 32'h55, 1, 6, 32'hA6);
        chk("full_pop_ready", 64'(aux_ready), 64'd0);
        chk("full_r0_we", 64'(rf_we), 64'd1);
        chk("full_r0_waddr", 64'(rf_waddr), 64'd2);
        chk("full_r0_wdata", 64'(rf_wdata), 64'hA2);
        tick();
        cyc(0, 1, 1, 32'h1, 1, 8, 32'hA8);

        // reset with two entries queued
        drive(1, 1, 1, 32'h1, 0, 0, 0);
        chk("rmid_count_before", 64'(buf_count), 64'd2);
        chk("rmid_we", 64'(rf_we), 64'd0);
        tick();
        drive(0, 0, 0, 0, 1, 0, 32'hBAD);
        chk("rmid_count", 64'(buf_count), 64'd0);
        chk("rmid_ready", 64'(aux_ready), 64'd1);
        chk("rmid_idle_we", 64'(rf_we), 64'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("r0_not_queued", 64'(buf_count), 64'd0);
        chk("r0_not_written", 64'(rf_we), 64'd0);
        tick();

        // randomized traffic with varying pipeline load
        pct = 60;
        for (int n = 0; n < 4000; n++) begin
            if (n % 250 == 0) begin
                case ($urandom_range(0, 2))
                    0:       pct = 20;
                    1:       pct = 60;
                    default: pct = 97;
                endcase
            end
            cyc(($urandom_range(0, 299) == 0),
                ($urandom_range(0, 99) < pct),
                5'($urandom_range(0, 7)),
                $urandom,
                bit'($urandom_range(0, 1)),
                5'($urandom_range(0, 7)),
                $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
